main_memory_responder: RTL and testbench
========================================

MAIN_MEMORY_RESPONDER -- requirements
Module: main_memory_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning request-accept to ready delay in cycles (legal 1..15).
REQ-002 SHALL have parameter INDEX_W, default 10, meaning line-index width (2**INDEX_W lines of 512 bits).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port addr, input, 32, request byte address.
REQ-006 SHALL have port wr_data, input, 512, write cacheline.
REQ-007 SHALL have port rw, input, 1, request type (0 = read, 1 = write).
REQ-008 SHALL have port valid, input, 1, request present.
REQ-009 SHALL have port rd_data, output, 512, read cacheline.
REQ-010 SHALL have port ready, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port proto_err, output, 1, sticky protocol-violation flag.
REQ-012 SHALL connect as the slave end of the memory interface, with signal directions matching the slave modport.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY and RESP.
REQ-014 IDLE SHALL accept a request at an edge where valid=1, latching addr, rw and wr_data, and moving to BUSY with counter = LATENCY-1; with LATENCY=1 it SHALL move directly to RESP.
REQ-015 BUSY SHALL decrement the counter each edge, move to RESP at the edge where the counter is 0, and ignore input changes.
REQ-016 ready SHALL be registered and high only in RESP, exactly one cycle, LATENCY cycles after the accept edge.
REQ-017 Line index SHALL be addr[6+INDEX_W-1:6]; addr[5:0] SHALL be ignored; upper bits SHALL be ignored, so addresses alias (wrap) modulo the array size.
REQ-018 A write SHALL update the array at the edge entering RESP; rd_data SHALL be unchanged by writes.
REQ-019 A read SHALL load rd_data from the array at the edge entering RESP; rd_data SHALL hold that value until the next read completes.
REQ-020 RESP SHALL return to IDLE unconditionally, so the earliest next accept is the edge after ready falls, and back-to-back requests SHALL be spaced LATENCY+1 cycles.
REQ-021 A read of a line written by the immediately preceding request SHALL return the new data.

Reset
REQ-022 rst low SHALL asynchronously force state IDLE, counter 0, ready 0, rd_data 0 and proto_err 0.
REQ-023 Reset mid-request SHALL abort the request with no array write and no ready pulse.
REQ-024 Reset SHALL NOT clear the array; the array SHALL be zero at simulation start.

Configuration
REQ-025 With MEM_PROTOCOL_CHECK_EN defined, proto_err SHALL set (until reset) when, in BUSY, valid drops or addr, rw or wr_data differ from the latched values.
REQ-026 Without MEM_PROTOCOL_CHECK_EN, proto_err SHALL be tied 0 and no checker logic SHALL be built.

Structure
REQ-027 Package mem_pkg SHALL hold ADDR_W=32, LINE_W=512, OFFSET_W=6 and the FSM state enum typedef.
REQ-028 The storage SHALL be a sub-module mem_line_array (1 write and 1 read port, synchronous, no reset).

Verification
REQ-029 Read of unwritten addr 0x0000_0040 with LATENCY=4 -> ready high exactly 4 cycles after the accept edge, for 1 cycle, with rd_data = 0.
REQ-030 Write 0xA5-pattern line to 0x0000_1000, then read 0x0000_1000 -> rd_data = 0xA5 pattern; rd_data unchanged during the write's ready.
REQ-031 Write line X to 0x0000_0000, then read 0x0001_0000 (INDEX_W=10) -> rd_data = X (alias); read 0x0000_003F -> X (offset ignored).
REQ-032 valid held high across 3 consecutive reads -> ready pulses LATENCY+1 cycles apart, each returning the correct line.
REQ-033 rst low 2 cycles after accepting a write to 0x80 -> no ready pulse; a later read of 0x80 returns the old data.
REQ-034 With MEM_PROTOCOL_CHECK_EN defined, addr changed in BUSY -> proto_err = 1 until rst; without the macro -> proto_err stays 0.

Source files
------------

// File: rtl/mem_pkg.sv
// ============================================================================
// mem_pkg : shared widths and FSM state type for the main memory responder
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam int ADDR_W   = 32;
  localparam int LINE_W   = 512;
  localparam int OFFSET_W = 6;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_line_array.sv
// ============================================================================
// mem_line_array : cacheline storage, one synchronous write and one synchronous read port
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_line_array
  import mem_pkg::*;
#(
  parameter int INDEX_W = 10
) (
  input  logic               clk,
  input  logic               we,
  input  logic [INDEX_W-1:0] waddr,
  input  logic [LINE_W-1:0]  wdata,
  input  logic               re,
  input  logic [INDEX_W-1:0] raddr,
  output logic [LINE_W-1:0]  rdata
);

  // Contents start at zero and survive reset.
  logic [LINE_W-1:0] lines [2**INDEX_W] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) lines[waddr] <= wdata;
    if (re) rdata <= lines[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/main_memory_responder.sv
// ============================================================================
// main_memory_responder : fixed-latency cacheline memory slave (IDLE/BUSY/RESP)
// Optional request-stability checker: define MEM_PROTOCOL_CHECK_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module main_memory_responder
  import mem_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int INDEX_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LINE_W-1:0] wr_data,
  input  logic              rw,
  input  logic              valid,
  output logic [LINE_W-1:0] rd_data,
  output logic              ready,
  output logic              proto_err
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  addr_q;
  logic               rw_q;
  logic [LINE_W-1:0]  wdata_q;
  logic               have_rd;

  logic [ADDR_W-1:0]  req_addr;
  logic               req_rw;
  logic [LINE_W-1:0]  req_wdata;
  logic               enter_resp;
  logic               arr_we;
  logic               arr_re;
  logic [INDEX_W-1:0] req_index;
  logic [LINE_W-1:0]  arr_rdata;
  logic               unused_addr_bits;

  // With LATENCY=1 the array is accessed on the accept edge itself, so the
  // live inputs are the request; otherwise the latched copy is.
  always_comb begin
    req_addr   = addr_q;
    req_rw     = rw_q;
    req_wdata  = wdata_q;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        req_addr   = addr;
        req_rw     = rw;
        req_wdata  = wr_data;
        enter_resp = valid && (LATENCY == 1);
      end
      BUSY:    enter_resp = (cnt <= CNT_W'(1));
      default: enter_resp = 1'b0;
    endcase
  end

  assign req_index        = req_addr[OFFSET_W +: INDEX_W];
  assign unused_addr_bits = ^{req_addr[OFFSET_W-1:0], req_addr[ADDR_W-1:OFFSET_W+INDEX_W]};
  assign arr_we           = rst && enter_resp && req_rw;
  assign arr_re           = rst && enter_resp && !req_rw;

  mem_line_array #(
    .INDEX_W (INDEX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (req_index),
    .wdata (req_wdata),
    .re    (arr_re),
    .raddr (req_index),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ready   <= 1'b0;
      have_rd <= 1'b0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            addr_q  <= addr;
            rw_q    <= rw;
            wdata_q <= wr_data;
            state   <= BUSY;
            cnt     <= CNT_W'(LATENCY - 1);
          end
        end
        BUSY:    cnt   <= cnt - 1'b1;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        state <= RESP;
        cnt   <= '0;
        ready <= 1'b1;
        if (!req_rw) have_rd <= 1'b1;
      end
    end
  end

  // Array output register has no reset; mask it until the first read lands.
  assign rd_data = have_rd ? arr_rdata : '0;

`ifdef MEM_PROTOCOL_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (state == BUSY &&
                 (!valid || addr != addr_q || rw != rw_q || wr_data != wdata_q)) begin
      err_q <= 1'b1;
    end
  end
  assign proto_err = err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_main_memory_responder.sv
// ============================================================================
// tb_main_memory_responder : random and directed checks against a line-level reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_main_memory_responder;

  localparam int LAT = 4;

  logic         clk;
  logic         rst;
  logic [31:0]  addr;
  logic [511:0] wr_data;
  logic         rw;
  logic         valid;
  logic [511:0] rd_data;
  logic         ready;
  logic         proto_err;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [511:0] model_mem [int];
  logic [511:0] last_rd;

  main_memory_responder #(.LATENCY(LAT), .INDEX_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .wr_data   (wr_data),
    .rw        (rw),
    .valid     (valid),
    .rd_data   (rd_data),
    .ready     (ready),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic int line_of(input logic [31:0] a);
    return int'(a[15:6]);
  endfunction

  function automatic logic [511:0] model_read(input logic [31:0] a);
    if (model_mem.exists(line_of(a))) return model_mem[line_of(a)];
    return '0;
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  // Drive one request starting at a negedge with the DUT idle; ready must
  // occupy exactly the LAT-th cycle after the accept edge.
  task automatic run_req(input string tag, input logic [31:0] a, input logic w,
                         input logic [511:0] d, input bit keep, output int rdy_cyc);
    addr = a; rw = w; wr_data = d; valid = 1'b1;
    rdy_cyc = -1;
    @(posedge clk);
    for (int i = 1; i <= LAT + 1; i++) begin
      @(negedge clk);
      check_val({tag, "_ready"}, 512'(ready), (i == LAT) ? 512'd1 : 512'd0);
      if (i == LAT) begin
        if (ready) rdy_cyc = cyc;
        if (w) begin
          check_val({tag, "_rd_hold"}, rd_data, last_rd);
          model_mem[line_of(a)] = d;
        end else begin
          last_rd = model_read(a);
          check_val({tag, "_rd_data"}, rd_data, last_rd);
        end
        if (!keep) valid = 1'b0;
      end
    end
  endtask

  initial begin
    int t0, t1, t2;
    logic [511:0] x;
    logic [511:0] old80;
    bit exp_err;
    rst = 1'b0; addr = '0; wr_data = '0; rw = 1'b0; valid = 1'b0;
    last_rd = '0;
`ifdef MEM_PROTOCOL_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    #1;
    check_val("rst_ready", 512'(ready), 512'd0);
    check_val("rst_rd_data", rd_data, '0);
    check_val("rst_proto_err", 512'(proto_err), 512'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    run_req("rd_unwritten", 32'h0000_0040, 1'b0, '0, 1'b0, t0);

    run_req("wr_a5", 32'h0000_1000, 1'b1, {64{8'hA5}}, 1'b0, t0);
    run_req("rd_a5", 32'h0000_1000, 1'b0, '0, 1'b0, t0);
    check_val("a5_pattern", rd_data, {64{8'hA5}});

    x = rand_line();
    run_req("wr_x", 32'h0000_0000, 1'b1, x, 1'b0, t0);
    run_req("rd_alias", 32'h0001_0000, 1'b0, '0, 1'b0, t0);
    check_val("alias_x", rd_data, x);
    run_req("rd_offset", 32'h0000_003F, 1'b0, '0, 1'b0, t0);
    check_val("offset_x", rd_data, x);

    run_req("b2b0", 32'h0000_1000, 1'b0, '0, 1'b1, t0);
    run_req("b2b1", 32'h0000_0000, 1'b0, '0, 1'b1, t1);
    run_req("b2b2", 32'h0000_0040, 1'b0, '0, 1'b0, t2);
    check_val("b2b_gap01", 512'(t1 - t0), 512'(LAT + 1));
    check_val("b2b_gap12", 512'(t2 - t1), 512'(LAT + 1));

    // Aborted write: reset two cycles after the accept edge.
    old80 = rand_line();
    run_req("wr_old80", 32'h0000_0080, 1'b1, old80, 1'b0, t0);
    addr = 32'h0000_0080; rw = 1'b1; wr_data = ~old80; valid = 1'b1;
    @(posedge clk);
    @(negedge clk); @(negedge clk);
    rst = 1'b0; valid = 1'b0;
    #1;
    check_val("abort_rd_data", rd_data, '0);
    check_val("abort_ready", 512'(ready), 512'd0);
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      check_val("abort_no_ready", 512'(ready), 512'd0);
    end
    rst = 1'b1;
    last_rd = '0;
    run_req("rd_after_abort", 32'h0000_0080, 1'b0, '0, 1'b0, t0);
    check_val("abort_old_data", rd_data, old80);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = $urandom;
      a[15:6] = 10'($urandom_range(0, 7));
      run_req("rand", a, 1'($urandom_range(0, 1)), rand_line(), 1'b0, t0);
    end

    // Address disturbed while BUSY; the latched address still governs.
    addr = 32'h0000_1000; rw = 1'b0; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    addr = 32'h0010_1000;
    @(negedge clk);
    check_val("proto_set", 512'(proto_err), 512'(exp_err));
    @(negedge clk);
    @(negedge clk);
    check_val("proto_ready", 512'(ready), 512'd1);
    last_rd = model_read(32'h0000_1000);
    check_val("proto_rd_data", rd_data, last_rd);
    valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("proto_sticky", 512'(proto_err), 512'(exp_err));
    rst = 1'b0;
    #1;
    check_val("proto_cleared", 512'(proto_err), 512'd0);
    @(negedge clk);
    rst = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
